// File: rtl/video_mnist_stat_pkg.sv
// -----------------------------------------------------------------------------
// video_mnist_stat_pkg
// Shared constants for the MNIST statistics stage:
//   NUM_CLASS       number of digit classes counted (0..9)
//   CORE_ID         value returned by the CORE_ID register
//   ADR_*           Wishbone word offsets (byte address = word << 2)
//   state_e         frame tracking state
// -----------------------------------------------------------------------------
package video_mnist_stat_pkg;

    localparam int          NUM_CLASS       = 10;
    localparam logic [31:0] CORE_ID         = 32'h527A_5700;

    localparam int          ADR_CORE_ID     = 'h00;
    localparam int          ADR_CTL         = 'h01;
    localparam int          ADR_PARAM_TH    = 'h02;
    localparam int          ADR_FRAME_COUNT = 'h03;
    localparam int          ADR_MAX_CLASS   = 'h04;
    localparam int          ADR_PIX_LAST    = 'h05;
    localparam int          ADR_HIST_BASE   = 'h10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/video_mnist_stat_argmax.sv
// -----------------------------------------------------------------------------
// video_mnist_stat_argmax
// Combinational search for the class with the largest histogram count.
//   hist_i       NUM_CLASS packed counters of HIST_WIDTH bits
//   max_class_o  index of the largest counter, lowest index wins a tie,
//                4'hF when every counter is zero
// -----------------------------------------------------------------------------
module video_mnist_stat_argmax
    import video_mnist_stat_pkg::*;
#(
    parameter int HIST_WIDTH = 20
) (
    input  logic [NUM_CLASS-1:0][HIST_WIDTH-1:0] hist_i,
    output logic [3:0]                           max_class_o
);

    logic [HIST_WIDTH-1:0] best_val;

    // Strict '>' keeps the earlier (lower) index on ties; starting from a
    // zero best value leaves 4'hF in place when nothing was counted.
    always_comb begin
        best_val    = '0;
        max_class_o = 4'hF;
        for (int c = 0; c < NUM_CLASS; c++) begin
            if (hist_i[c] > best_val) begin
                best_val    = hist_i[c];
                max_class_o = 4'(c);
            end
        end
    end

endmodule

// File: rtl/video_mnist_stat.sv
// -----------------------------------------------------------------------------
// video_mnist_stat
// Statistics stage between video_mnist_cnn and video_mnist_color. Forwards the
// classified stream through one register slice, builds a per-frame histogram
// of confident digit classifications and snapshots it at every frame start.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   s_axi4s_*             classified pixel stream in (tuser[0] = frame start)
//   m_axi4s_*             registered copy of the input stream
//   s_wb_*                Wishbone slave, zero wait state, combinational read
//   irq_frame             one-cycle pulse after each snapshot
//
// Build option:
//   VIDEO_MNIST_STAT_ARGMAX_EN  registers MAX_CLASS (argmax of the snapshot)
//                               at each commit; otherwise MAX_CLASS reads 0.
// -----------------------------------------------------------------------------
module video_mnist_stat
    import video_mnist_stat_pkg::*;
#(
    parameter int          TUSER_WIDTH   = 1,
    parameter int          NUMBER_WIDTH  = 4,
    parameter int          COUNT_WIDTH   = 4,
    parameter int          HIST_WIDTH    = 20,
    parameter int          WB_ADR_WIDTH  = 8,
    parameter int          WB_DAT_WIDTH  = 32,
    parameter int          WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
    parameter int          INIT_PARAM_TH = 1,
    parameter logic        INIT_PARAM_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [TUSER_WIDTH-1:0]  s_axi4s_tuser,
    input  logic                    s_axi4s_tlast,
    input  logic [NUMBER_WIDTH-1:0] s_axi4s_tnumber,
    input  logic [COUNT_WIDTH-1:0]  s_axi4s_tcount,
    input  logic                    s_axi4s_tvalid,
    output logic                    s_axi4s_tready,

    output logic [TUSER_WIDTH-1:0]  m_axi4s_tuser,
    output logic                    m_axi4s_tlast,
    output logic [NUMBER_WIDTH-1:0] m_axi4s_tnumber,
    output logic [COUNT_WIDTH-1:0]  m_axi4s_tcount,
    output logic                    m_axi4s_tvalid,
    input  logic                    m_axi4s_tready,

    input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
    input  logic                    s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
    input  logic                    s_wb_stb_i,
    output logic                    s_wb_ack_o,

    output logic                    irq_frame
);

    // ---------------------------------------------------------------- stream
    logic accept;

    assign s_axi4s_tready = !m_axi4s_tvalid || m_axi4s_tready;
    assign accept         = s_axi4s_tvalid && s_axi4s_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_axi4s_tuser   <= '0;
            m_axi4s_tlast   <= 1'b0;
            m_axi4s_tnumber <= '0;
            m_axi4s_tcount  <= '0;
            m_axi4s_tvalid  <= 1'b0;
        end else if (accept) begin
            m_axi4s_tuser   <= s_axi4s_tuser;
            m_axi4s_tlast   <= s_axi4s_tlast;
            m_axi4s_tnumber <= s_axi4s_tnumber;
            m_axi4s_tcount  <= s_axi4s_tcount;
            m_axi4s_tvalid  <= 1'b1;
        end else if (m_axi4s_tready) begin
            m_axi4s_tvalid  <= 1'b0;
        end
    end

    // ------------------------------------------------------------ statistics
    state_e                              state_q, state_d;
    logic [NUM_CLASS-1:0][HIST_WIDTH-1:0] work_q, work_d, snap_q;
    logic [31:0]                         work_pix_q, work_pix_d;
    logic [31:0]                         pix_last_q, frame_count_q;
    logic                                irq_q;
    logic                                param_en_q;
    logic [COUNT_WIDTH-1:0]              param_th_q;
    logic                                start, commit, count_en, hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            work_q     <= '0;
            work_pix_q <= '0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            work_pix_q <= work_pix_d;
        end
    end

    // A frame-start beat clears the working set and then counts itself, so
    // the start pixel always belongs to the frame it opens.
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        work_pix_d = work_pix_q;
        start      = accept && s_axi4s_tuser[0];
        commit     = start && (state_q == ACTIVE);
        count_en   = accept && ((state_q == ACTIVE) || start);
        hit        = param_en_q
                  && (s_axi4s_tnumber < NUMBER_WIDTH'(NUM_CLASS))
                  && (s_axi4s_tcount >= param_th_q);
        if (start) begin
            state_d    = ACTIVE;
            work_d     = '0;
            work_pix_d = '0;
        end
        if (count_en) begin
            if (work_pix_d != '1)
                work_pix_d = work_pix_d + 32'd1;
            for (int c = 0; c < NUM_CLASS; c++) begin
                if (hit && (s_axi4s_tnumber == NUMBER_WIDTH'(c)) && (work_d[c] != '1))
                    work_d[c] = work_d[c] + HIST_WIDTH'(1);
            end
        end
    end

    // Commit copies the pre-beat working set, so registered reads in the
    // commit cycle still see the previous snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q        <= '0;
            pix_last_q    <= '0;
            frame_count_q <= '0;
            irq_q         <= 1'b0;
        end else begin
            irq_q <= commit;
            if (commit) begin
                snap_q        <= work_q;
                pix_last_q    <= work_pix_q;
                frame_count_q <= frame_count_q + 32'd1;
            end
        end
    end

    assign irq_frame = irq_q;

`ifdef VIDEO_MNIST_STAT_ARGMAX_EN
    logic [3:0] max_class_q, max_class_c;

    video_mnist_stat_argmax #(
        .HIST_WIDTH (HIST_WIDTH)
    ) u_argmax (
        .hist_i      (work_q),
        .max_class_o (max_class_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            max_class_q <= 4'hF;
        else if (commit)
            max_class_q <= max_class_c;
    end
`endif

    // ------------------------------------------------------------- wishbone
    logic                    wr_ctl, wr_th;
    logic [WB_DAT_WIDTH-1:0] wmask, ctl_new, th_new, rdata;

    assign s_wb_ack_o = s_wb_stb_i;
    assign wr_ctl     = s_wb_stb_i && s_wb_we_i && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CTL));
    assign wr_th      = s_wb_stb_i && s_wb_we_i && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_PARAM_TH));

    // Byte-lane merge of write data into the current register value.
    always_comb begin
        wmask = '0;
        for (int b = 0; b < WB_DAT_WIDTH; b++)
            wmask[b] = s_wb_sel_i[b/8];
        ctl_new = (WB_DAT_WIDTH'(param_en_q) & ~wmask) | (s_wb_dat_i & wmask);
        th_new  = (WB_DAT_WIDTH'(param_th_q) & ~wmask) | (s_wb_dat_i & wmask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            param_en_q <= INIT_PARAM_EN;
            param_th_q <= COUNT_WIDTH'(INIT_PARAM_TH);
        end else begin
            if (wr_ctl) param_en_q <= ctl_new[0];
            if (wr_th)  param_th_q <= th_new[COUNT_WIDTH-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        case (s_wb_adr_i)
            WB_ADR_WIDTH'(ADR_CORE_ID):     rdata = WB_DAT_WIDTH'(CORE_ID);
            WB_ADR_WIDTH'(ADR_CTL):         rdata = WB_DAT_WIDTH'(param_en_q);
            WB_ADR_WIDTH'(ADR_PARAM_TH):    rdata = WB_DAT_WIDTH'(param_th_q);
            WB_ADR_WIDTH'(ADR_FRAME_COUNT): rdata = WB_DAT_WIDTH'(frame_count_q);
`ifdef VIDEO_MNIST_STAT_ARGMAX_EN
            WB_ADR_WIDTH'(ADR_MAX_CLASS):   rdata = WB_DAT_WIDTH'(max_class_q);
`endif
            WB_ADR_WIDTH'(ADR_PIX_LAST):    rdata = WB_DAT_WIDTH'(pix_last_q);
            default: begin
                for (int c = 0; c < NUM_CLASS; c++) begin
                    if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_HIST_BASE + c))
                        rdata = WB_DAT_WIDTH'(snap_q[c]);
                end
            end
        endcase
    end

    assign s_wb_dat_o = reset ? '0 : rdata;

endmodule

// File: tb/tb_video_mnist_stat.sv
module tb_video_mnist_stat;
    import video_mnist_stat_pkg::*;

    localparam int HW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:0]  s_tuser = '0;
    logic        s_tlast = 1'b0;
    logic [3:0]  s_tnumber = '0;
    logic [3:0]  s_tcount = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [0:0]  m_tuser;
    logic        m_tlast;
    logic [3:0]  m_tnumber;
    logic [3:0]  m_tcount;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [7:0]  wb_adr = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_sel = '0;
    logic        wb_stb = 1'b0;
    logic        wb_ack;
    logic        irq_frame;

    always #5 clk = ~clk;

    video_mnist_stat #(.HIST_WIDTH(HW)) dut (
        .clk(clk), .reset(reset),
        .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tnumber(s_tnumber),
        .s_axi4s_tcount(s_tcount), .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
        .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tnumber(m_tnumber),
        .m_axi4s_tcount(m_tcount), .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready),
        .s_wb_adr_i(wb_adr), .s_wb_dat_i(wb_dat_i), .s_wb_dat_o(wb_dat_o), .s_wb_we_i(wb_we),
        .s_wb_sel_i(wb_sel), .s_wb_stb_i(wb_stb), .s_wb_ack_o(wb_ack), .irq_frame(irq_frame)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [10:0] sb[$];
    bit          m_act;
    int unsigned m_work[NUM_CLASS], m_snap[NUM_CLASS];
    logic [31:0] m_pix, m_pixlast, m_fc;
    int          m_th;
    bit          m_en;
    int          irq_cnt = 0;
    int          tready_mode = 0;  // 0: always ready, 1: random, 2: stalled

    task automatic model_reset();
        m_act = 0; m_pix = 0; m_pixlast = 0; m_fc = 0; m_th = 1; m_en = 1;
        for (int c = 0; c < NUM_CLASS; c++) begin m_work[c] = 0; m_snap[c] = 0; end
    endtask

    task automatic model_step(input logic tu, input logic [3:0] num, input logic [3:0] cnt,
                              output bit commit);
        commit = 0;
        if (tu) begin
            if (m_act) begin
                commit = 1;
                for (int c = 0; c < NUM_CLASS; c++) m_snap[c] = m_work[c];
                m_pixlast = m_pix;
                m_fc = m_fc + 1;
            end
            m_act = 1;
            m_pix = 0;
            for (int c = 0; c < NUM_CLASS; c++) m_work[c] = 0;
        end
        if (m_act) begin
            if (m_pix != 32'hFFFF_FFFF) m_pix = m_pix + 1;
            if (m_en && num <= 9 && int'(cnt) >= m_th && m_work[num] < (1 << HW) - 1)
                m_work[num] = m_work[num] + 1;
        end
    endtask

    function automatic logic [31:0] exp_max();
`ifdef VIDEO_MNIST_STAT_ARGMAX_EN
        int unsigned bv = 0;
        logic [31:0] bi = 32'hF;
        for (int c = 0; c < NUM_CLASS; c++)
            if (m_snap[c] > bv) begin bv = m_snap[c]; bi = c; end
        return bi;
`else
        return 32'h0;
`endif
    endfunction

    // ------------------------------------------------------------ processes
    always @(posedge clk) begin
        #1;
        case (tready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (irq_frame) irq_cnt++;
            if (m_tvalid && !m_tready) chk("stall_tready", 32'(s_tready), 32'd0);
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) chk("extra_beat", 32'd1, 32'd0);
                else chk("beat", 32'({m_tuser, m_tlast, m_tnumber, m_tcount}), 32'(sb.pop_front()));
            end
        end
    end

    // ---------------------------------------------------------------- tasks
    task automatic send_beat(input logic tu, input logic tl, input logic [3:0] num,
                             input logic [3:0] cnt);
        bit done = 0;
        bit commit;
        s_tuser = tu; s_tlast = tl; s_tnumber = num; s_tcount = cnt; s_tvalid = 1'b1;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            if (s_tready) begin
                sb.push_back({tu, tl, num, cnt});
                model_step(tu, num, cnt, commit);
                @(posedge clk); #1;
                s_tvalid = 1'b0;
                chk("irq", 32'(irq_frame), 32'(commit));
                done = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            chk("accept_timeout", 32'd0, 32'd1);
            s_tvalid = 1'b0;
        end
    endtask

    task automatic send_frame(input int npix, input int mode, input logic [3:0] cnt);
        logic [3:0] num, c;
        for (int i = 0; i < npix; i++) begin
            c = cnt;
            case (mode)
                0: num = (i < 8) ? 4'd7 : (i < 13) ? 4'd2 : 4'd10;
                1: num = 4'd3;
                2: num = (i < 20) ? 4'd3 : 4'd5;
                default: begin
                    num = 4'($urandom_range(0, 11));
                    c   = 4'($urandom_range(0, 15));
                end
            endcase
            send_beat(i == 0, (i % 4) == 3, num, c);
        end
    endtask

    task automatic wb_write(input int adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_adr = 8'(adr); wb_dat_i = dat; wb_sel = sel; wb_we = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        wb_stb = 1'b0; wb_we = 1'b0; wb_sel = '0;
    endtask

    task automatic wb_read(input int adr, output logic [31:0] d);
        wb_adr = 8'(adr); wb_we = 1'b0; wb_stb = 1'b1;
        #1;
        d = wb_dat_o;
        chk("wb_ack", 32'(wb_ack), 32'd1);
        wb_stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rd_chk(input string tag, input int adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(adr, d);
        chk(tag, d, exp);
    endtask

    task automatic check_snapshot(input string tag);
        for (int c = 0; c < NUM_CLASS; c++)
            rd_chk($sformatf("%s_hist%0d", tag, c), ADR_HIST_BASE + c, m_snap[c]);
        rd_chk({tag, "_pix_last"}, ADR_PIX_LAST, m_pixlast);
        rd_chk({tag, "_frame_count"}, ADR_FRAME_COUNT, m_fc);
        rd_chk({tag, "_max_class"}, ADR_MAX_CLASS, exp_max());
        chk({tag, "_irq_count"}, irq_cnt, m_fc);
    endtask

    // ----------------------------------------------------------------- main
    initial begin
        logic [31:0] d;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_data", 32'({m_tuser, m_tlast, m_tnumber, m_tcount}), 32'd0);
        chk("rst_irq", 32'(irq_frame), 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        rd_chk("rst_core_id", ADR_CORE_ID, 32'h527A_5700);
        rd_chk("rst_ctl", ADR_CTL, 32'd1);
        rd_chk("rst_param_th", ADR_PARAM_TH, 32'd1);
        rd_chk("rst_frame_count", ADR_FRAME_COUNT, 32'd0);
        rd_chk("rst_hist0", ADR_HIST_BASE, 32'd0);
        rd_chk("unmapped", 'h3F, 32'd0);

        // Beats before the first frame start pass through uncounted.
        repeat (3) send_beat(1'b0, 1'b0, 4'd4, 4'd3);
        rd_chk("idle_frame_count", ADR_FRAME_COUNT, 32'd0);

        // 4x4 frame: 8x digit 7, 5x digit 2, 3x class 10.
        send_frame(16, 0, 4'd3);
        send_beat(1'b1, 1'b0, 4'd11, 4'd0);
        rd_chk("f1_hist7", ADR_HIST_BASE + 7, 32'd8);
        rd_chk("f1_hist2", ADR_HIST_BASE + 2, 32'd5);
        rd_chk("f1_pix_last", ADR_PIX_LAST, 32'd16);
        rd_chk("f1_frame_count", ADR_FRAME_COUNT, 32'd1);
`ifdef VIDEO_MNIST_STAT_ARGMAX_EN
        rd_chk("f1_max_class", ADR_MAX_CLASS, 32'd7);
`else
        rd_chk("f1_max_class", ADR_MAX_CLASS, 32'd0);
`endif
        check_snapshot("f1");

        // Threshold above tcount: nothing counted; sel=0 and RO writes ignored.
        wb_write(ADR_PARAM_TH, 32'h0000_0104, 4'b0001);
        m_th = 4;
        rd_chk("th_write", ADR_PARAM_TH, 32'd4);
        wb_write(ADR_PARAM_TH, 32'h0000_0009, 4'b0000);
        rd_chk("th_sel0", ADR_PARAM_TH, 32'd4);
        wb_write(ADR_CORE_ID, 32'h0, 4'hF);
        rd_chk("core_id_ro", ADR_CORE_ID, 32'h527A_5700);
        send_frame(16, 0, 4'd3);
        send_beat(1'b1, 1'b0, 4'd11, 4'd0);
        rd_chk("th_hist7", ADR_HIST_BASE + 7, 32'd0);
`ifdef VIDEO_MNIST_STAT_ARGMAX_EN
        rd_chk("th_max_class", ADR_MAX_CLASS, 32'hF);
`endif
        check_snapshot("th");
        wb_write(ADR_PARAM_TH, 32'd1, 4'b0001);
        m_th = 1;

        // Statistics disabled: frame still commits.
        wb_write(ADR_CTL, 32'd0, 4'hF);
        m_en = 0;
        rd_chk("ctl_off", ADR_CTL, 32'd0);
        send_frame(16, 0, 4'd3);
        send_beat(1'b1, 1'b0, 4'd11, 4'd0);
        rd_chk("dis_hist7", ADR_HIST_BASE + 7, 32'd0);
        rd_chk("dis_pix_last", ADR_PIX_LAST, 32'd16);
        check_snapshot("dis");
        wb_write(ADR_CTL, 32'd1, 4'hF);
        m_en = 1;

        // Saturation at 2^HW-1 and tie-break.
        send_frame(20, 1, 4'd3);
        send_beat(1'b1, 1'b0, 4'd11, 4'd0);
        rd_chk("sat_hist3", ADR_HIST_BASE + 3, 32'd15);
        check_snapshot("sat");
        send_frame(40, 2, 4'd3);
        send_beat(1'b1, 1'b0, 4'd11, 4'd0);
        rd_chk("tie_hist5", ADR_HIST_BASE + 5, 32'd15);
`ifdef VIDEO_MNIST_STAT_ARGMAX_EN
        rd_chk("tie_max_class", ADR_MAX_CLASS, 32'd3);
`endif
        check_snapshot("tie");

        // Random backpressure over three frames.
        tready_mode = 1;
        repeat (3) begin
            send_frame(12, 3, 4'd0);
            send_beat(1'b1, 1'b0, 4'd11, 4'd0);
            check_snapshot("rnd");
        end
        tready_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("drain", sb.size(), 32'd0);

        // Reset while the output slice holds a beat.
        tready_mode = 2;
        @(posedge clk); #2;
        send_beat(1'b0, 1'b1, 4'd5, 4'd5);
        chk("pre_rst_m_tvalid", 32'(m_tvalid), 32'd1);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_irq", 32'(irq_frame), 32'd0);
        rd_chk("mid_rst_frame_count", ADR_FRAME_COUNT, 32'd0);
        rd_chk("mid_rst_hist3", ADR_HIST_BASE + 3, 32'd0);
        sb.delete();
        model_reset();
        irq_cnt = 0;
        @(negedge clk); reset = 1'b0; tready_mode = 0;
        @(posedge clk); #2;
        check_snapshot("post_rst");
        rd_chk("post_rst_param_th", ADR_PARAM_TH, 32'd1);
        rd_chk("post_rst_ctl", ADR_CTL, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
